// File: rtl/inc_dec_arbiter.sv
// Round-robin arbiter that shares one registered increment/decrement unit among NUM_REQ requesters.
// Optional counters are enabled by defining INC_DEC_ARB_STATS_EN.
module inc_dec_arbiter #(
   parameter int WIDTH   = 8,
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ-1:0]       req_inc,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_result,
   output logic                     rsp_cout
`ifdef INC_DEC_ARB_STATS_EN
   ,
   input  logic                     stat_clr,
   output logic [15:0]              stat_grants,
   output logic [15:0]              stat_stalls
`endif
);

   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  sel;
   logic             found;
   logic             can_issue;
   logic [WIDTH-1:0] sel_a;
   logic             sel_inc;
   logic [WIDTH:0]   sum;

   assign can_issue = !rsp_valid || rsp_ready;

   // Scan upward from ptr with wrap; the first asserted request wins.
   always_comb begin
      int idx;
      idx     = 0;
      found   = 1'b0;
      sel     = '0;
      sel_a   = '0;
      sel_inc = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ)
            idx = idx - NUM_REQ;
         if (!found && req[idx]) begin
            found   = 1'b1;
            sel     = ID_W'(idx);
            sel_a   = req_a[idx*WIDTH +: WIDTH];
            sel_inc = req_inc[idx];
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (!rst && can_issue && found)
         gnt[sel] = 1'b1;
   end

   // The extra top bit is the carry for increment and the borrow for decrement.
   always_comb begin
      if (sel_inc)
         sum = {1'b0, sel_a} + (WIDTH+1)'(1);
      else
         sum = {1'b0, sel_a} - (WIDTH+1)'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_cout   <= 1'b0;
         ptr        <= '0;
      end else if (can_issue) begin
         if (found) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= sel;
            rsp_result <= sum[WIDTH-1:0];
            rsp_cout   <= sum[WIDTH];
            ptr        <= (sel == ID_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
         end else begin
            rsp_valid  <= 1'b0;
         end
      end
   end

`ifdef INC_DEC_ARB_STATS_EN
   logic grant_any;
   logic stall;

   assign grant_any = |gnt;
   assign stall     = |req && !can_issue;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_grants <= '0;
         stat_stalls <= '0;
      end else if (stat_clr) begin
         stat_grants <= '0;
         stat_stalls <= '0;
      end else begin
         if (grant_any && stat_grants != 16'hFFFF)
            stat_grants <= stat_grants + 16'd1;
         if (stall && stat_stalls != 16'hFFFF)
            stat_stalls <= stat_stalls + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inc_dec_arbiter.sv
// Self-checking bench for inc_dec_arbiter: directed steps followed by random traffic,
// compared against a behavioural model of arbitration, arithmetic and back-pressure.
module tb_inc_dec_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_a;
   logic [N-1:0]   req_inc;
   logic [N-1:0]   gnt;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_result;
   logic           rsp_cout;
`ifdef INC_DEC_ARB_STATS_EN
   logic           stat_clr;
   logic [15:0]    stat_grants;
   logic [15:0]    stat_stalls;
`endif

   logic [W-1:0] a_arr [N];
   assign req_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};

   inc_dec_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_a      (req_a),
      .req_inc    (req_inc),
      .gnt        (gnt),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_cout   (rsp_cout)
`ifdef INC_DEC_ARB_STATS_EN
      ,
      .stat_clr   (stat_clr),
      .stat_grants(stat_grants),
      .stat_stalls(stat_stalls)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   int txn        = 0;

   // Reference model state
   bit m_valid;
   int m_id, m_res, m_cout, m_ptr;
   int m_grants, m_stalls;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_id = 0; m_res = 0; m_cout = 0; m_ptr = 0;
      m_grants = 0; m_stalls = 0;
   endtask

   task automatic set_op(input int i, input int a, input bit inc);
      a_arr[i]   = W'(a);
      req_inc[i] = inc;
   endtask

   // One clock: inputs already applied; checks gnt before the edge and the response after it.
   task automatic cycle();
      bit can, found, clr;
      int g, a, idx;
      logic [N-1:0] exp_gnt;
      #1;
      can = !m_valid || rsp_ready;
      found = 0; g = 0; exp_gnt = '0;
      if (can) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!found && req[idx]) begin
               found = 1; g = idx;
            end
         end
      end
      if (found) exp_gnt[g] = 1'b1;
      chk("gnt", 32'(gnt), 32'(exp_gnt));
`ifdef INC_DEC_ARB_STATS_EN
      clr = stat_clr;
`else
      clr = 0;
`endif
      if (clr) begin
         m_grants = 0; m_stalls = 0;
      end else begin
         if (found && m_grants < 65535) m_grants++;
         if ((req != 0) && !can && m_stalls < 65535) m_stalls++;
      end
      @(posedge clk);
      if (can) begin
         if (found) begin
            a = int'(a_arr[g]);
            m_valid = 1;
            m_id    = g;
            m_res   = req_inc[g] ? (a + 1) % 256 : (a + 255) % 256;
            m_cout  = req_inc[g] ? int'(a == 255) : int'(a == 0);
            m_ptr   = (g + 1) % N;
         end else begin
            m_valid = 0;
         end
      end
      #1;
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
         chk("rsp_id", 32'(rsp_id), 32'(m_id));
         chk("rsp_result", 32'(rsp_result), 32'(m_res));
         chk("rsp_cout", 32'(rsp_cout), 32'(m_cout));
      end
`ifdef INC_DEC_ARB_STATS_EN
      chk("stat_grants", 32'(stat_grants), 32'(m_grants));
      chk("stat_stalls", 32'(stat_stalls), 32'(m_stalls));
`endif
      $display("txn %0d req=%b gnt=%b rsp_valid=%b rsp_id=%0d rsp_result=%h rsp_cout=%b",
               txn, req, exp_gnt, rsp_valid, rsp_id, rsp_result, rsp_cout);
      txn++;
   endtask

   initial begin
      rst = 1'b1; req = '1; req_inc = '0; rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) a_arr[i] = '0;
`ifdef INC_DEC_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      model_reset();
      #2;
      chk("gnt_in_reset", 32'(gnt), 32'h0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      req = '0;
      #1;
      chk("reset_valid", 32'(rsp_valid), 32'h0);
      chk("reset_id", 32'(rsp_id), 32'h0);
      chk("reset_result", 32'(rsp_result), 32'h0);
      chk("reset_cout", 32'(rsp_cout), 32'h0);

      // Single request: requester 2 increments 0x7F
      set_op(2, 8'h7F, 1'b1); req = 4'b0100;
      cycle();
      chk("single_result", 32'(rsp_result), 32'h80);
      chk("single_id", 32'(rsp_id), 32'd2);

      // Wrap boundaries
      set_op(0, 8'hFF, 1'b1); req = 4'b0001; cycle();
      chk("inc_ff_cout", 32'(rsp_cout), 32'd1);
      set_op(1, 8'h00, 1'b0); req = 4'b0010; cycle();
      chk("dec_00_result", 32'(rsp_result), 32'hFF);
      set_op(3, 8'h01, 1'b0); req = 4'b1000; cycle();
      chk("dec_01_cout", 32'(rsp_cout), 32'd0);

      // Round-robin rotation with everybody requesting
      for (int i = 0; i < N; i++) set_op(i, 16 * i + 3, i[0]);
      req = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("rr_id", 32'(rsp_id), 32'(i % N));
      end

      // Back-pressure: grant 3, then stall for three cycles, then release
      req = 4'b1000; cycle();
      rsp_ready = 1'b0; req = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_id_hold", 32'(rsp_id), 32'd3);
      end
      rsp_ready = 1'b1; cycle();
      chk("bp_next_id", 32'(rsp_id), 32'd0);

`ifdef INC_DEC_ARB_STATS_EN
      req = '0; stat_clr = 1'b1; cycle(); stat_clr = 1'b0;
      req = 4'b0001;
      for (int i = 0; i < 5; i++) cycle();
      rsp_ready = 1'b0; req = 4'b1111;
      for (int i = 0; i < 3; i++) cycle();
      chk("stats_grants5", 32'(stat_grants), 32'd5);
      chk("stats_stalls3", 32'(stat_stalls), 32'd3);
      stat_clr = 1'b1; cycle(); stat_clr = 1'b0;
      chk("stats_clr_grants", 32'(stat_grants), 32'd0);
      chk("stats_clr_stalls", 32'(stat_stalls), 32'd0);
      rsp_ready = 1'b1;
`endif

      // Random traffic
      for (int t = 0; t < 300; t++) begin
         req       = N'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 255), 1'($urandom_range(0, 1)));
         if (t % 50 == 7) set_op(t % N, 8'hFF, 1'b1);
         if (t % 50 == 9) set_op(t % N, 8'h00, 1'b0);
`ifdef INC_DEC_ARB_STATS_EN
         stat_clr = ($urandom_range(0, 15) == 0);
`endif
         cycle();
      end
`ifdef INC_DEC_ARB_STATS_EN
      stat_clr = 1'b0;
`endif

      // Reset mid-stream while a response is valid
      rsp_ready = 1'b1; req = 4'b0001; set_op(0, 8'h10, 1'b1); cycle();
      chk("pre_reset_valid", 32'(rsp_valid), 32'd1);
      req = 4'b1111;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(rsp_valid), 32'd0);
      chk("async_rst_gnt", 32'(gnt), 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      req = 4'b1010; set_op(1, 8'h22, 1'b0); set_op(3, 8'h33, 1'b1);
      cycle();
      chk("post_reset_id", 32'(rsp_id), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end
endmodule
